js_adc_reader: RTL and testbench



---
 rtl/js_adc_reader_if.sv | 23 ++
 rtl/js_adc_reader.sv | 181 ++++++++++++++++++
 tb/tb_js_adc_reader.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/js_adc_reader_if.sv
// Joystick ADC reader bus: SPI pins toward the ADC plus the position
// outputs toward the cursor mover.
interface js_adc_reader_if;
  logic       miso;
  logic       sclk;
  logic       mosi;
  logic       cs_n;
  logic [7:0] positionX;
  logic [7:0] positionY;
  logic       valid;

  // Reader side: drives SPI and positions, receives ADC data
  modport master (
    input  miso,
    output sclk, mosi, cs_n, positionX, positionY, valid
  );

  // ADC / consumer side
  modport slave (
    output miso,
    input  sclk, mosi, cs_n, positionX, positionY, valid
  );
endinterface

// File: rtl/js_adc_reader.sv
// Joystick ADC reader: polls X (channel 0) then Y (channel 1) of a 10-bit
// SPI ADC, converts each reading to a saturated signed offset from CENTER
// and publishes both axes together with a one-cycle valid pulse.
module js_adc_reader #(
  parameter int unsigned CLK_DIV       = 25,
  parameter int unsigned SAMPLE_PERIOD = 50000,
  parameter int unsigned CENTER        = 128
) (
  input logic             clk,
  input logic             reset_n,
  js_adc_reader_if.master bus
);

  typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD} state_t;

  localparam int unsigned MAXC = (SAMPLE_PERIOD > CLK_DIV) ? SAMPLE_PERIOD : CLK_DIV;
  localparam int unsigned CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SP_LAST  = CW'(SAMPLE_PERIOD - 1);
  localparam logic signed [9:0] CENTER_S = 10'(CENTER);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [4:0]    next_bit;
  logic          sclk_q, sclk_d;
  logic          cs_n_q, cs_n_d;
  logic          mosi_q, mosi_d;
  logic          ch_q, ch_d;
  logic [9:0]    shift_q, shift_d;
  logic [7:0]    x_hold_q, x_hold_d;
  logic [7:0]    pos_x_q, pos_x_d;
  logic [7:0]    pos_y_q, pos_y_d;
  logic          valid_q, valid_d;

  // Signed offset of an 8-bit reading from CENTER, clamped to [-128,127]
  function automatic logic [7:0] to_offset(input logic [7:0] u);
    logic signed [9:0] d;
    d = $signed({2'b00, u}) - CENTER_S;
    if (d > 10'sd127)       return 8'h7F;
    else if (d < -10'sd128) return 8'h80;
    else                    return d[7:0];
  endfunction

  // Command word, bit 0 first: start, single-ended, channel, MSB-first
  function automatic logic cmd_bit(input logic ch, input logic [4:0] b);
    case (b)
      5'd0, 5'd1, 5'd3: return 1'b1;
      5'd2:             return ch;
      default:          return 1'b0;
    endcase
  endfunction

  assign next_bit = {1'b0, bit_q} + 5'd1;

  // Next-state and next-output logic for the polling sequence
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    sclk_d   = sclk_q;
    cs_n_d   = cs_n_q;
    mosi_d   = mosi_q;
    ch_d     = ch_q;
    shift_d  = shift_q;
    x_hold_d = x_hold_q;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    valid_d  = 1'b0;

    case (state_q)
      IDLE: begin
        cs_n_d = 1'b1;
        sclk_d = 1'b0;
        if (cnt_q == SP_LAST) begin
          cnt_d   = '0;
          state_d = CS_SETUP;
          cs_n_d  = 1'b0;
          mosi_d  = cmd_bit(ch_q, 5'd0);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      CS_SETUP: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // Falling edge: only the last 10 bits survive the shift,
            // so the leading null/command-echo bits fall out naturally.
            sclk_d  = 1'b0;
            shift_d = {shift_q[8:0], bus.miso};
            mosi_d  = cmd_bit(ch_q, next_bit);
            if (bit_q == 4'd15) begin
              state_d = CS_HOLD;
              cs_n_d  = 1'b1;
            end else begin
              bit_d = next_bit[3:0];
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      CS_HOLD: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!ch_q) begin
            x_hold_d = to_offset(shift_q[9:2]);
            ch_d     = 1'b1;
            state_d  = CS_SETUP;
            cs_n_d   = 1'b0;
            mosi_d   = cmd_bit(1'b1, 5'd0);
          end else begin
            pos_x_d = x_hold_q;
            pos_y_d = to_offset(shift_q[9:2]);
            valid_d = 1'b1;
            ch_d    = 1'b0;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      sclk_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      mosi_q   <= 1'b0;
      ch_q     <= 1'b0;
      shift_q  <= '0;
      x_hold_q <= '0;
      pos_x_q  <= '0;
      pos_y_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sclk_q   <= sclk_d;
      cs_n_q   <= cs_n_d;
      mosi_q   <= mosi_d;
      ch_q     <= ch_d;
      shift_q  <= shift_d;
      x_hold_q <= x_hold_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.sclk      = sclk_q;
  assign bus.cs_n      = cs_n_q;
  assign bus.mosi      = mosi_q;
  assign bus.positionX = pos_x_q;
  assign bus.positionY = pos_y_q;
  assign bus.valid     = valid_q;

endmodule

// File: tb/tb_js_adc_reader.sv
// Bench for js_adc_reader: an ADC model answers each frame with chosen raw
// readings; a timeline model predicts SPI pins, positions and valid on
// every cycle. Two instances (CENTER 128 and 100) run in lockstep.
module tb_js_adc_reader;
  localparam int CD = 2;
  localparam int SP = 100;
  localparam int P  = SP + 68 * CD;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic miso_bit = 1'b0;

  always #5 clk = ~clk;

  js_adc_reader_if bus0 ();
  js_adc_reader_if bus1 ();
  assign bus0.miso = miso_bit;
  assign bus1.miso = miso_bit;

  js_adc_reader #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP), .CENTER(128)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0));
  js_adc_reader #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP), .CENTER(100)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1));

  int nvec = 0;
  int nerr = 0;
  int t = 0;
  int pbase = 0;
  bit armed = 0;
  logic [9:0] rx [16];
  logic [9:0] ry [16];
  logic ev = 0;
  logic [7:0] ex0 = 0, ey0 = 0, ex1 = 0, ey1 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s t=%0d got %0h expected %0h", nm, t, act, exp);
    end
  endtask

  function automatic logic [7:0] conv(input int raw, input int center);
    int d;
    d = raw / 4 - center;
    if (d > 127)  d = 127;
    if (d < -128) d = -128;
    return 8'(d);
  endfunction

  function automatic bit cs_low(input int p);
    return (p >= SP && p < SP + 33 * CD) || (p >= SP + 34 * CD && p < SP + 67 * CD);
  endfunction

  function automatic int offs(input int p);
    return (p >= SP + 34 * CD) ? p - SP - 34 * CD : p - SP;
  endfunction

  function automatic bit exp_sclk(input int p);
    int o;
    if (!cs_low(p)) return 1'b0;
    o = offs(p);
    return (o >= CD) && (((o - CD) / CD) % 2 == 1);
  endfunction

  function automatic bit exp_mosi(input int p);
    int o, b;
    if (!cs_low(p)) return 1'b0;
    o = offs(p);
    b = (o < CD) ? 0 : (o - CD) / (2 * CD);
    if (b == 0 || b == 1 || b == 3) return 1'b1;
    if (b == 2) return (p >= SP + 34 * CD);
    return 1'b0;
  endfunction

  // Timeline model: cycles since the last reset edge; updates every P cycles
  always @(posedge clk) begin
    int idx;
    if (!reset_n) begin
      t <= 0; ev <= 0; ex0 <= 0; ey0 <= 0; ex1 <= 0; ey1 <= 0; armed <= 1;
    end else begin
      if ((t + 1) % P == 0) begin
        idx = pbase + (t + 1) / P - 1;
        ev  <= 1;
        ex0 <= conv(int'(rx[idx]), 128);
        ey0 <= conv(int'(ry[idx]), 128);
        ex1 <= conv(int'(rx[idx]), 100);
        ey1 <= conv(int'(ry[idx]), 100);
      end else begin
        ev <= 0;
      end
      t <= t + 1;
    end
  end

  // ADC model: counts SCLK falls, takes channel from command bit 2,
  // random filler for bits 0..5, raw reading MSB first in bits 6..15
  int abit = 0;
  logic adc_ch = 0;
  logic prev_cs = 1, prev_sclk = 0;
  always @(negedge clk) begin
    int idx;
    logic [9:0] word;
    if (bus0.cs_n) begin
      abit = 0;
      miso_bit = 1'($urandom);
    end else begin
      if (prev_cs) abit = 0;
      else if (prev_sclk && !bus0.sclk) abit = abit + 1;
      if (!prev_sclk && bus0.sclk && abit == 2) adc_ch = bus0.mosi;
      if (abit < 6 || abit > 15) begin
        miso_bit = 1'($urandom);
      end else begin
        idx = (pbase + t / P) % 16;
        word = adc_ch ? ry[idx] : rx[idx];
        miso_bit = word[15 - abit];
      end
    end
    prev_cs = bus0.cs_n;
    prev_sclk = bus0.sclk;
  end

  // Per-cycle compare against the timeline model
  always @(negedge clk) begin
    int p;
    if (armed) begin
      p = t % P;
      chk("cs_n", bus0.cs_n, cs_low(p) ? 0 : 1);
      chk("sclk", bus0.sclk, exp_sclk(p));
      chk("mosi", bus0.mosi, exp_mosi(p));
      chk("valid0", bus0.valid, ev);
      chk("posX0", bus0.positionX, ex0);
      chk("posY0", bus0.positionY, ey0);
      chk("cs_n1", bus1.cs_n, cs_low(p) ? 0 : 1);
      chk("valid1", bus1.valid, ev);
      chk("posX1", bus1.positionX, ex1);
      chk("posY1", bus1.positionY, ey1);
    end
  end

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus0.valid && n < 2000);
    if (!bus0.valid) begin
      nvec++; nerr++;
      $display("FAIL %s_timeout got no valid within %0d cycles", nm, n);
    end else begin
      chk({nm, "_latency"}, n, 236);
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++) begin
      rx[i] = 10'($urandom_range(0, 1023));
      ry[i] = 10'($urandom_range(0, 1023));
    end
    rx[0] = 10'h3FF; ry[0] = 10'h000;
    rx[1] = 10'h200; ry[1] = 10'h200;
    rx[2] = 10'h000; ry[2] = 10'h3FF;
    rx[3] = 10'h3FD;

    repeat (5) @(negedge clk);
    chk("rst_cs_n", bus0.cs_n, 1);
    chk("rst_sclk", bus0.sclk, 0);
    chk("rst_posX", bus0.positionX, 8'h00);
    chk("rst_valid", bus0.valid, 0);
    reset_n = 1'b1;

    wait_valid("pair0");
    chk("p0_posX", bus0.positionX, 8'h7F);
    chk("p0_posY", bus0.positionY, 8'h80);
    chk("p0_c100_posX", bus1.positionX, 8'h7F);
    chk("p0_c100_posY", bus1.positionY, 8'h9C);
    wait_valid("pair1");
    chk("p1_posX", bus0.positionX, 8'h00);
    chk("p1_posY", bus0.positionY, 8'h00);
    chk("p1_c100_posX", bus1.positionX, 8'h1C);
    wait_valid("pair2");
    chk("p2_c100_posX", bus1.positionX, 8'h9C);
    chk("p2_c100_posY", bus1.positionY, 8'h7F);
    wait_valid("pair3");
    chk("p3_posX", bus0.positionX, 8'h7F);

    // Abort during bit 9 of the next Y frame
    n = 0;
    while (t != 4 * P + SP + 34 * CD + CD + 18 * CD + 1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("abort_point_reached", n < 2000, 1);
    chk("pre_abort_sclk_active", bus0.cs_n, 0);
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort_cs_n", bus0.cs_n, 1);
    chk("abort_posX", bus0.positionX, 8'h00);
    chk("abort_valid", bus0.valid, 0);
    repeat (2) @(negedge clk);
    pbase = 8;
    reset_n = 1'b1;

    wait_valid("post_abort0");
    wait_valid("post_abort1");
    wait_valid("post_abort2");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, time limit reached");
    $fatal(1);
  end
endmodule
